soustracteur_serie: RTL

//   Bit-serial N-bit unsigned subtractor: computes diff = a - b, LSB first, one bit per clock.

---
 rtl/soustracteur_serie_pkg.sv | 14 +
 rtl/soustracteur_serie_if.sv | 27 ++
 rtl/soustracteur_1bit.sv | 23 ++
 rtl/soustracteur_serie.sv | 106 ++++++++++
 4 files changed

// File: rtl/soustracteur_serie_pkg.sv
// ----------------------------------------------------------------------------
// soustracteur_serie_pkg
//   Shared definitions for the bit-serial subtractor: FSM state type and
//   state encodings.
// ----------------------------------------------------------------------------
package soustracteur_serie_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/soustracteur_serie_if.sv
// ----------------------------------------------------------------------------
// soustracteur_serie_if
//   Start/done handshake and operand/result bus of the serial subtractor.
//   master : requester (drives start, a, b; observes busy, done, diff, bout)
//   slave  : subtractor (observes start, a, b; drives busy, done, diff, bout)
// ----------------------------------------------------------------------------
interface soustracteur_serie_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/soustracteur_1bit.sv
// ----------------------------------------------------------------------------
// soustracteur_1bit
//   Combinational full subtractor: d = a - b - bin.
//   i_a    : minuend bit
//   i_b    : subtrahend bit
//   i_bin  : borrow in
//   o_d    : difference bit
//   o_bout : borrow out
// ----------------------------------------------------------------------------
module soustracteur_1bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    logic w_x;

    assign w_x    = i_a ^ i_b;
    assign o_d    = w_x ^ i_bin;
    // Borrow when a<b outright, or when a==b and a borrow is pending.
    assign o_bout = (~i_a & i_b) | (~w_x & i_bin);
endmodule

// File: rtl/soustracteur_serie.sv
// ----------------------------------------------------------------------------
// soustracteur_serie
//   Bit-serial N-bit unsigned subtractor, diff = a - b mod 2^N, LSB first,
//   one bit per clock, with a start/done handshake.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : slave side of soustracteur_serie_if
//             start/a/b in; busy (SHIFT), done (1-cycle pulse), diff, bout out
// ----------------------------------------------------------------------------
module soustracteur_serie
    import soustracteur_serie_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    soustracteur_serie_if.slave   bus
);
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    state_t         r_state, w_state_d;
    logic [N-1:0]   r_ra, w_ra_d;
    logic [N-1:0]   r_rb, w_rb_d;
    logic           r_borrow, w_borrow_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [N-1:0]   r_diff, w_diff_d;
    logic           r_bout, w_bout_d;

    logic           w_d;
    logic           w_bit_bout;

    soustracteur_1bit u_sub (
        .i_a    (r_ra[0]),
        .i_b    (r_rb[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bit_bout)
    );

    always_comb begin
        w_state_d  = r_state;
        w_ra_d     = r_ra;
        w_rb_d     = r_rb;
        w_borrow_d = r_borrow;
        w_cnt_d    = r_cnt;
        w_diff_d   = r_diff;
        w_bout_d   = r_bout;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_d  = ST_SHIFT;
                    w_ra_d     = bus.a;
                    w_rb_d     = bus.b;
                    w_borrow_d = 1'b0;
                    w_cnt_d    = '0;
                    w_diff_d   = '0;
                    w_bout_d   = 1'b0;
                end
            end
            ST_SHIFT: begin
                w_ra_d     = {1'b0, r_ra[N-1:1]};
                w_rb_d     = {1'b0, r_rb[N-1:1]};
                w_diff_d   = {w_d, r_diff[N-1:1]};
                w_borrow_d = w_bit_bout;
                if (r_cnt == CntW'(N - 1)) begin
                    // Last bit: publish the borrow; counter is held so it never wraps.
                    w_bout_d  = w_bit_bout;
                    w_state_d = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_ra     <= '0;
            r_rb     <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_ra     <= w_ra_d;
            r_rb     <= w_rb_d;
            r_borrow <= w_borrow_d;
            r_cnt    <= w_cnt_d;
            r_diff   <= w_diff_d;
            r_bout   <= w_bout_d;
        end
    end

    assign bus.busy = (r_state == ST_SHIFT);
    assign bus.done = (r_state == ST_DONE);
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
endmodule
